// File: rtl/poly_pkg.sv
// Shared types and constants for the Horner polynomial evaluator.
package poly_pkg;

  localparam int DEF_DATA_W  = 32;
  localparam int DEF_MAX_DEG = 8;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  // Width needed to encode values 0..n-1; never below 1 so ports stay legal.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/poly_coef_rf.sv
// Coefficient register file: DEPTH registers, one write port, one combinational read port.
module poly_coef_rf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 9,
  parameter int AW     = 4
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DEPTH-1:0][DATA_W-1:0] regs_q;

  // Decoded per-entry enables drop addresses beyond DEPTH-1 without a bounds check.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      regs_q <= '0;
    end else if (we_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (waddr_i == AW'(i)) regs_q[i] <= wdata_i;
      end
    end
  end

  always_comb begin
    rdata_o = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (raddr_i == AW'(i)) rdata_o = regs_q[i];
    end
  end

endmodule

// File: rtl/poly_horner.sv
// Polynomial evaluator: sum(coef[i]*x^i) via Horner's rule, one multiply-add per cycle.
module poly_horner
  import poly_pkg::*;
#(
  parameter  int DATA_W  = DEF_DATA_W,
  parameter  int MAX_DEG = DEF_MAX_DEG,
  localparam int AW      = clog2(MAX_DEG + 1)
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  output logic              busy,
  output logic              done,
  input  logic              stall,
  output logic [DATA_W-1:0] returndata,
  input  logic [DATA_W-1:0] idx,
  input  logic [AW-1:0]     deg,
  input  logic              coef_we,
  input  logic [AW-1:0]     coef_addr,
  input  logic [DATA_W-1:0] coef_data
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic [DATA_W-1:0] x_q, x_d;
  logic [AW-1:0]     cnt_q, cnt_d;
  logic [AW-1:0]     deg_clamp;
  logic [AW-1:0]     rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic              rf_we;

  assign deg_clamp = (deg > AW'(MAX_DEG)) ? AW'(MAX_DEG) : deg;
  assign rf_we     = coef_we && (state_q == S_IDLE);

  // Read is combinational off the pre-edge register contents, so a same-cycle
  // write and start sees the old coefficient.
  poly_coef_rf #(
    .DATA_W (DATA_W),
    .DEPTH  (MAX_DEG + 1),
    .AW     (AW)
  ) u_coef_rf (
    .clk_i   (clock),
    .rst_n_i (resetn),
    .we_i    (rf_we),
    .waddr_i (coef_addr),
    .wdata_i (coef_data),
    .raddr_i (rd_addr),
    .rdata_o (rd_data)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      x_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      x_q     <= x_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    x_d     = x_q;
    cnt_d   = cnt_q;
    rd_addr = cnt_q - AW'(1);
    case (state_q)
      S_IDLE: begin
        rd_addr = deg_clamp;
        if (start) begin
          x_d     = idx;
          acc_d   = rd_data;
          cnt_d   = deg_clamp;
          state_d = (deg_clamp == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        // Product truncates to DATA_W bits in this assignment context.
        acc_d = acc_q * x_q + rd_data;
        cnt_d = cnt_q - AW'(1);
        if (cnt_q == AW'(1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (!stall) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign returndata = done ? acc_q : '0;

endmodule

// File: tb/tb_poly_horner.sv
// Self-checking bench for poly_horner: vector table plus corner-case sequences.
module tb_poly_horner;

  localparam int DW = 32;
  localparam int MD = 8;

  typedef logic [MD:0][DW-1:0] coefs_t;

  typedef struct {
    string       name;
    coefs_t      c;
    logic [3:0]  deg;
    logic [31:0] x;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  logic          clock, resetn, start, busy, done, stall, coef_we;
  logic [DW-1:0] returndata, idx, coef_data;
  logic [3:0]    deg, coef_addr;

  int checks, errors;
  logic [31:0] exp_q[$];
  coefs_t cur;

  poly_horner #(.DATA_W(DW), .MAX_DEG(MD)) dut (
    .clock      (clock),
    .resetn     (resetn),
    .start      (start),
    .busy       (busy),
    .done       (done),
    .stall      (stall),
    .returndata (returndata),
    .idx        (idx),
    .deg        (deg),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_data  (coef_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Direct power-sum reference, deliberately not Horner-ordered.
  function automatic logic [31:0] poly_eval(input coefs_t c, input int d, input logic [31:0] x);
    logic [31:0] s, p;
    int dd;
    dd = (d > MD) ? MD : d;
    s = '0;
    p = 32'd1;
    for (int i = 0; i <= dd; i++) begin
      s = s + c[i] * p;
      p = p * x;
    end
    return s;
  endfunction

  task automatic write_all(input coefs_t c);
    for (int i = 0; i <= MD; i++) begin
      @(negedge clock);
      coef_we = 1'b1; coef_addr = 4'(i); coef_data = c[i];
    end
    @(negedge clock);
    coef_we = 1'b0;
    cur = c;
  endtask

  // Called at a negedge; drives start now, measures edges to done, pops scoreboard.
  task automatic run_call(input string nm, input logic [3:0] d, input logic [31:0] x,
                          input logic [31:0] exp, input int exp_lat);
    int lat;
    logic [31:0] want;
    bit nz;
    exp_q.push_back(exp);
    start = 1'b1; deg = d; idx = x;
    nz = 1'b0;
    @(posedge clock);
    lat = 1;
    @(negedge clock);
    start = 1'b0; coef_we = 1'b0;
    while (!done && lat < 40) begin
      if (returndata !== '0) nz = 1'b1;
      @(posedge clock);
      lat++;
      @(negedge clock);
    end
    chk({nm, "_lat"}, 32'(lat), 32'(exp_lat));
    chk({nm, "_rd0"}, 32'(nz), 32'd0);
    want = exp_q.pop_front();
    chk({nm, "_res"}, returndata, want);
    if (!stall) begin
      @(negedge clock);
      chk({nm, "_idle"}, {30'd0, busy, done}, 32'd0);
    end
  endtask

  vec_t vt[5];
  coefs_t tmp;
  logic [31:0] e;
  bit seen;

  initial begin
    checks = 0; errors = 0;
    resetn = 1'b0; start = 1'b0; stall = 1'b0; coef_we = 1'b0;
    idx = '0; deg = '0; coef_addr = '0; coef_data = '0; cur = '0;

    #12;
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_rdata", returndata, 32'd0);

    // First start right at release is accepted on the first edge.
    @(negedge clock);
    resetn = 1'b1;
    run_call("first", 4'd2, 32'd7, 32'd0, 3);

    for (int i = 0; i <= MD; i++) tmp[i] = 32'd1;
    vt[0] = '{"ones_d8", tmp, 4'd8, 32'd2, 32'd511, 9};
    tmp[0] = 32'h1234;
    vt[1] = '{"deg0", tmp, 4'd0, 32'd7, 32'h1234, 1};
    tmp = '0; tmp[2] = 32'd1; tmp[1] = 32'd1;
    vt[2] = '{"wrap", tmp, 4'd2, 32'h0001_0000, 32'h0001_0000, 3};
    for (int i = 0; i <= MD; i++) tmp[i] = 32'h9e37_79b9 * 32'(i + 1) + 32'h55;
    vt[3] = '{"rand_d5", tmp, 4'd5, 32'hdead_beef, poly_eval(tmp, 5, 32'hdead_beef), 6};
    for (int i = 0; i <= MD; i++) tmp[i] = 32'(3 * i + 1);
    vt[4] = '{"clamp15", tmp, 4'd15, 32'd5, poly_eval(tmp, 8, 32'd5), 9};

    for (int v = 0; v < 5; v++) begin
      write_all(vt[v].c);
      run_call(vt[v].name, vt[v].deg, vt[v].x, vt[v].exp, vt[v].lat);
    end
    run_call("clamp8", 4'd8, 32'd5, vt[4].exp, 9);

    // Stall in DONE: hold outputs, ignore start pulses, leave on first stall=0 edge.
    e = poly_eval(cur, 2, 32'd3);
    stall = 1'b1;
    run_call("stall", 4'd2, 32'd3, e, 3);
    for (int k = 0; k < 5; k++) begin
      start = k[0]; deg = 4'd0;
      @(negedge clock);
      chk("stall_hold", {done, returndata[30:0]}, {1'b1, e[30:0]});
    end
    start = 1'b0; stall = 1'b0;
    @(negedge clock);
    chk("stall_rel", {30'd0, busy, done}, 32'd0);
    @(negedge clock);
    chk("stall_noq", {30'd0, busy, done}, 32'd0);

    // Coefficient write during CALC is dropped; repeat call matches.
    e = poly_eval(cur, 8, 32'd3);
    fork
      run_call("wr_calc", 4'd8, 32'd3, e, 9);
      begin
        repeat (4) @(negedge clock);
        coef_we = 1'b1; coef_addr = 4'd4; coef_data = 32'hdead;
        @(negedge clock);
        coef_we = 1'b0;
      end
    join
    run_call("wr_calc_rep", 4'd8, 32'd3, e, 9);

    // Out-of-range write address leaves the file untouched.
    @(negedge clock);
    coef_we = 1'b1; coef_addr = 4'd12; coef_data = 32'hffff_ffff;
    @(negedge clock);
    coef_we = 1'b0;
    run_call("oob_wr", 4'd8, 32'd3, e, 9);

    // Same-cycle write and start: call uses old coef[0], next call sees new.
    e = cur[0];
    coef_we = 1'b1; coef_addr = 4'd0; coef_data = 32'h0bad_f00d;
    run_call("wr_start", 4'd0, 32'd9, e, 1);
    run_call("wr_after", 4'd0, 32'd9, 32'h0bad_f00d, 1);

    // Reset in the middle of CALC aborts the call and clears coefficients.
    start = 1'b1; deg = 4'd8; idx = 32'd2;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (3) @(posedge clock);
    #2 resetn = 1'b0;
    #1;
    chk("mid_rst", {29'd0, busy, done, |returndata}, 32'd0);
    @(negedge clock);
    resetn = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clock);
      if (done || busy) seen = 1'b1;
    end
    chk("no_done_after_rst", 32'(seen), 32'd0);
    run_call("post_rst_d3", 4'd3, 32'd5, 32'd0, 4);
    run_call("post_rst_d8", 4'd8, 32'd1, 32'd0, 9);

    chk("sb_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/poly_horner.md
POLY_HORNER -- requirements
Module: poly_horner

Interface
REQ-001 SHALL have parameter DATA_W, default 32: operand, coefficient and result width.
REQ-002 SHALL have parameter MAX_DEG, default 8: highest supported polynomial degree; AW = clog2(MAX_DEG+1).
REQ-003 SHALL have port clock  in  1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port resetn  in  1: reset, asynchronous, active-low.
REQ-005 SHALL have port start  in  1: call valid.
REQ-006 SHALL have port busy  out  1: call stall; high when a start would not be accepted.
REQ-007 SHALL have port done  out  1: return valid.
REQ-008 SHALL have port stall  in  1: return stall from the consumer.
REQ-009 SHALL have port returndata  out  DATA_W: polynomial result.
REQ-010 SHALL have port idx  in  DATA_W: evaluation point x, sampled with start.
REQ-011 SHALL have port deg  in  AW: runtime degree, sampled with start.
REQ-012 SHALL have ports coef_we  in  1, coef_addr  in  AW, coef_data  in  DATA_W: coefficient write; coef[i] multiplies x^i.

Function
REQ-013 SHALL evaluate sum(coef[i]*x^i, i=0..deg) by Horner's rule, one multiply-add per cycle.
REQ-014 SHALL compute all arithmetic modulo 2^DATA_W: product truncated to the low DATA_W bits, sum wraps silently.
REQ-015 SHALL implement states IDLE, CALC, DONE; busy = (state != IDLE).
REQ-016 IDLE: start=1 accepts a call; x <= idx; d = min(deg, MAX_DEG); acc <= coef[d]; cnt <= d; next state DONE if d==0, else CALC.
REQ-017 CALC: acc <= acc*x + coef[cnt-1]; cnt <= cnt-1; next state DONE when cnt==1, else CALC.
REQ-018 SHALL raise done exactly d+1 rising edges after the edge that accepts start.
REQ-019 DONE: done=1, returndata=acc; next state IDLE at an edge with stall=0; hold state, done and returndata while stall=1.
REQ-020 returndata SHALL be 0 whenever done=0.
REQ-021 start while busy=1 SHALL be ignored, with no queuing.
REQ-022 coef writes SHALL take effect only in IDLE with coef_addr <= MAX_DEG; writes while busy, or to addresses above MAX_DEG, SHALL be ignored.
REQ-023 coef_we and start in the same IDLE cycle: the write SHALL complete, and the call SHALL use the pre-write coefficient value.
REQ-024 deg > MAX_DEG SHALL be clamped to MAX_DEG.

Reset
REQ-025 resetn=0 SHALL asynchronously force state=IDLE, busy=0, done=0, returndata=0, acc=0, cnt=0, x=0 and all coef[i]=0.
REQ-026 Reset asserted mid-call SHALL abort the call; no done SHALL follow release.
REQ-027 The first start after reset release SHALL be accepted on the first rising edge.

Structure
REQ-028 Shared package poly_pkg SHALL hold the state enum, the default DATA_W/MAX_DEG constants and the clog2 helper.
REQ-029 Coefficient storage SHALL be the sub-module poly_coef_rf: MAX_DEG+1 registers, one write port, one combinational read port.
REQ-030 The FSM, the counter and the multiply-add datapath SHALL reside in poly_horner.

Verification
REQ-031 All coefs=1, deg=8, idx=2 -> done at edge 9 after start, returndata=511.
REQ-032 coef[0]=0x1234, deg=0, idx=7 -> done at edge 1 after start, returndata=0x1234.
REQ-033 coef[2]=1, coef[1]=1, coef[0]=0, deg=2, idx=0x00010000 -> returndata=0x00010000 (wraps).
REQ-034 stall=1 for 5 cycles in DONE -> done and returndata held; start pulses meanwhile are ignored; returns to IDLE on the first stall=0 edge.
REQ-035 coef write during CALC, then a repeat call -> both results equal the pre-write value; deg=15 with MAX_DEG=8 -> result identical to deg=8.
REQ-036 resetn pulse at CALC cycle 3 -> busy=0, done=0, all coefs read 0; the next call with deg=3 returns 0.
